// File: rtl/dma_controller_pkg.sv
// dma_controller_pkg: state encoding and burst geometry shared by the DMA engine and the CPU arbitration logic
package dma_controller_pkg;
  localparam int BURST_WORDS = 12;
  localparam int BLOCK_WORDS = 4;
  localparam logic [3:0] DMA_LAST_INDEX = 4'(BURST_WORDS - 1);
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_REQ     = 3'd1;
  localparam state_t S_XFER    = 3'd2;
  localparam state_t S_RELEASE = 3'd3;
  localparam state_t S_DONE    = 3'd4;
  localparam state_t S_YIELD   = 3'd5;
  function automatic logic block_end(input logic [3:0] idx, input int block);
    return (int'(idx) % block) == block - 1;
  endfunction
endpackage

// File: rtl/dma_word_buffer.sv
// dma_word_buffer: single-entry valid/data holding register between device capture and memory write
module dma_word_buffer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;
  // load wins over clear; the controller never asserts both in one cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_clear) r_valid <= 1'b0;
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/dma_controller.sv
// dma_controller: BR/BG bus-mastering DMA moving a fixed burst from a device port into data memory; DMA_CYCLE_STEAL_EN releases the bus between blocks
module dma_controller
  import dma_controller_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int BURST_WORDS = dma_controller_pkg::BURST_WORDS,
  parameter int BLOCK_WORDS = dma_controller_pkg::BLOCK_WORDS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  output logic                 BR,
  input  logic                 BG,
  input  logic                 dev_valid,
  input  logic [WORD_SIZE-1:0] dev_data,
  output logic                 dev_ready,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_data,
  input  logic                 mem_ack,
  output logic [3:0]           dma_state,
  output logic                 dma_done
);
`ifdef DMA_CYCLE_STEAL_EN
  localparam logic STEAL = 1'b1;
`else
  localparam logic STEAL = 1'b0;
`endif
  localparam logic [3:0] LAST = 4'(BURST_WORDS - 1);
  state_t               r_state;
  logic [WORD_SIZE-1:0] r_base;
  logic [3:0]           r_idx;
  logic                 w_xfer, w_write, w_ack, w_load, w_block_end, w_buf_valid;
  logic [WORD_SIZE-1:0] w_buf_data;
  assign w_xfer      = r_state == S_XFER;
  assign w_write     = w_xfer && w_buf_valid && BG;
  assign w_ack       = w_write && mem_ack;
  assign w_load      = dev_valid && dev_ready;
  assign w_block_end = STEAL && block_end(r_idx, BLOCK_WORDS);
  dma_word_buffer #(.W(WORD_SIZE)) u_buf (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_clear(w_ack),
    .i_data (dev_data),
    .o_valid(w_buf_valid),
    .o_data (w_buf_data)
  );
  // command/arbitration sequencer; the index holds the last value until DONE so the CPU sees 11 through release
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_idx   <= '0;
    end else
      case (r_state)
        S_IDLE:
          if (cmd_valid) begin
            r_base  <= cmd_addr;
            r_idx   <= '0;
            r_state <= S_REQ;
          end
        S_REQ: if (BG) r_state <= S_XFER;
        S_XFER:
          if (w_ack) begin
            if (r_idx == LAST) r_state <= S_RELEASE;
            else begin
              r_idx <= r_idx + 4'd1;
              if (w_block_end) r_state <= S_YIELD;
            end
          end
        S_RELEASE: if (!BG) r_state <= S_DONE;
        S_YIELD:   if (!BG) r_state <= S_REQ;
        S_DONE: begin
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
  assign cmd_ready = r_state == S_IDLE;
  assign BR        = r_state == S_REQ || w_xfer;
  assign dev_ready = w_xfer && !w_buf_valid && BG;
  assign mem_write = w_write;
  assign mem_addr  = r_base + WORD_SIZE'(r_idx);
  assign mem_data  = w_buf_data;
  assign dma_state = r_idx;
  assign dma_done  = r_state == S_DONE;
endmodule

// File: tb/tb_dma_controller.sv
// tb_dma_controller: randomized CPU/device/memory environment around dma_controller with a word-sequence reference model
module tb_dma_controller;
  import dma_controller_pkg::*;
  localparam int W = 16;
  localparam int N = BURST_WORDS;
`ifdef DMA_CYCLE_STEAL_EN
  localparam int EXP_GRANTS = N / BLOCK_WORDS;
`else
  localparam int EXP_GRANTS = 1;
`endif
  logic clk = 1'b0, reset = 1'b0, cmd_valid = 1'b0, BG = 1'b0, dev_valid = 1'b0, mem_ack = 1'b0;
  logic [W-1:0] cmd_addr = '0, dev_data = '0;
  logic cmd_ready, BR, dev_ready, mem_write, dma_done;
  logic [W-1:0] mem_addr, mem_data;
  logic [3:0] dma_state;
  always #5 clk = ~clk;
  dma_controller dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .BR(BR), .BG(BG), .dev_valid(dev_valid), .dev_data(dev_data), .dev_ready(dev_ready),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .dma_state(dma_state), .dma_done(dma_done)
  );
  int n_checks = 0, n_fail = 0;
  logic [W-1:0] obs_addr[$], obs_data[$];
  logic [3:0] obs_idx[$];
  logic [W-1:0] dev_words[N];
  int done_cycles, grants, br_falls, unstable, bg_viol, timeout;
  logic cmd_rdy0, br_after_last, ready_after;
  logic [3:0] state_after;
  logic rst_br, rst_mw, rst_ready, rst_done;
  logic [3:0] rst_state;
  // drives one command through the environment and records what the DUT wrote; no judgement here
  task automatic run_burst(input logic [W-1:0] base, input int ack_wait, input int dev_pct,
                           input int gap_at, input int rst_at);
    int wcnt = 0, lat = 0, gap = 0, dev_i = 0;
    logic gap_used = 0, br_s = 0, prev_hold = 0, last_seen = 0, br_checked = 0;
    logic [W-1:0] pa = '0, pd = '0;
    logic [3:0] ps = '0;
    obs_addr.delete(); obs_data.delete(); obs_idx.delete();
    done_cycles = 0; grants = 0; br_falls = 0; unstable = 0; bg_viol = 0; timeout = 1;
    br_after_last = 1'bx; ready_after = 1'bx; state_after = 'x;
    for (int i = 0; i < N; i++) dev_words[i] = W'($urandom);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = base;
    #1 cmd_rdy0 = cmd_ready;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (rst_at >= 0 && obs_addr.size() == rst_at) begin
        reset = 1'b1;
        #1;
        rst_br = BR; rst_mw = mem_write; rst_ready = cmd_ready; rst_state = dma_state; rst_done = dma_done;
        @(negedge clk);
        reset = 1'b0; BG = 1'b0; mem_ack = 1'b0; dev_valid = 1'b0; cmd_valid = 1'b0;
        timeout = 0;
        return;
      end
      cmd_valid = done_cycles == 0 && $urandom_range(0, 7) == 0;
      cmd_addr = W'($urandom);
      if (gap_at >= 0 && !gap_used && obs_addr.size() == gap_at && BG) begin
        gap = 5; gap_used = 1;
      end
      if (gap > 0) begin
        BG = 1'b0; gap--;
      end else if (br_s && !BG) begin
        if (lat == 0) begin BG = 1'b1; grants++; lat = $urandom_range(0, 3); end else lat--;
      end else if (!br_s && BG) begin
        if (lat == 0) begin BG = 1'b0; lat = $urandom_range(0, 3); end else lat--;
      end
      dev_valid = dev_i < N && $urandom_range(1, 100) <= dev_pct;
      dev_data = dev_valid ? dev_words[dev_i] : W'($urandom);
      #1;
      wcnt = mem_write ? wcnt + 1 : 0;
      mem_ack = mem_write ? wcnt > ack_wait : $urandom_range(0, 3) == 0;
      #1;
      if ((mem_write || dev_ready) && !BG) bg_viol++;
      if (prev_hold && mem_write && {mem_addr, mem_data, dma_state} !== {pa, pd, ps}) unstable++;
      if (prev_hold && !mem_write && BG) unstable++;
      prev_hold = mem_write && !mem_ack;
      pa = mem_addr; pd = mem_data; ps = dma_state;
      if (dev_valid && dev_ready) dev_i++;
      if (last_seen && !br_checked) begin br_after_last = BR; br_checked = 1; end
      if (mem_write && mem_ack) begin
        obs_addr.push_back(mem_addr); obs_data.push_back(mem_data); obs_idx.push_back(dma_state);
        if (obs_addr.size() == N) last_seen = 1;
      end
      if (br_s && !BR) br_falls++;
      br_s = BR;
      if (dma_done) done_cycles++;
      else if (done_cycles > 0) begin
        ready_after = cmd_ready; state_after = dma_state; timeout = 0;
        return;
      end
    end
  endtask
  task automatic test_reset();
    #2 reset = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    n_checks++; if (BR !== 1'b0) begin n_fail++; $display("FAIL reset_BR: got %b expected 0", BR); end
    n_checks++; if (dev_ready !== 1'b0) begin n_fail++; $display("FAIL reset_dev_ready: got %b expected 0", dev_ready); end
    n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write: got %b expected 0", mem_write); end
    n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    n_checks++; if (mem_data !== '0) begin n_fail++; $display("FAIL reset_mem_data: got %h expected 0", mem_data); end
    n_checks++; if (dma_state !== 4'd0) begin n_fail++; $display("FAIL reset_dma_state: got %0d expected 0", dma_state); end
    n_checks++; if (dma_done !== 1'b0) begin n_fail++; $display("FAIL reset_dma_done: got %b expected 0", dma_done); end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_basic();
    logic [W-1:0] base = 16'h0100;
    run_burst(base, 0, 100, -1, -1);
    n_checks++; if (timeout != 0) begin n_fail++; $display("FAIL basic_timeout: burst never completed"); end
    n_checks++; if (cmd_rdy0 !== 1'b1) begin n_fail++; $display("FAIL basic_cmd_ready: got %b expected 1", cmd_rdy0); end
    n_checks++; if (obs_addr.size() != N) begin n_fail++; $display("FAIL basic_count: got %0d writes expected %0d", obs_addr.size(), N); end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (i >= obs_addr.size() || {obs_addr[i], obs_data[i], obs_idx[i]} !== {W'(base + W'(i)), dev_words[i], 4'(i)}) begin
        n_fail++; $display("FAIL basic_word[%0d]: got %h/%h/%0d expected %h/%h/%0d", i,
          i < obs_addr.size() ? obs_addr[i] : 'x, i < obs_addr.size() ? obs_data[i] : 'x, i < obs_addr.size() ? obs_idx[i] : 'x,
          W'(base + W'(i)), dev_words[i], i);
      end
    end
    n_checks++; if (done_cycles != 1) begin n_fail++; $display("FAIL basic_done_pulse: got %0d cycles expected 1", done_cycles); end
    n_checks++; if (br_after_last !== 1'b0) begin n_fail++; $display("FAIL basic_br_after_last: got %b expected 0", br_after_last); end
    n_checks++; if (grants != EXP_GRANTS) begin n_fail++; $display("FAIL basic_grants: got %0d expected %0d", grants, EXP_GRANTS); end
    n_checks++; if (br_falls != EXP_GRANTS) begin n_fail++; $display("FAIL basic_br_falls: got %0d expected %0d", br_falls, EXP_GRANTS); end
    n_checks++; if ({ready_after, state_after} !== 5'b1_0000) begin n_fail++; $display("FAIL basic_idle_after: got ready=%b state=%0d expected ready=1 state=0", ready_after, state_after); end
    n_checks++; if (bg_viol != 0) begin n_fail++; $display("FAIL basic_bg_gating: got %0d violations expected 0", bg_viol); end
  endtask
  task automatic test_ack_delay();
    logic [W-1:0] base = 16'h2000;
    run_burst(base, 3, 100, -1, -1);
    n_checks++; if (timeout != 0) begin n_fail++; $display("FAIL ackdly_timeout: burst never completed"); end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL ackdly_stable: got %0d unstable cycles expected 0", unstable); end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (i >= obs_addr.size() || {obs_addr[i], obs_data[i], obs_idx[i]} !== {W'(base + W'(i)), dev_words[i], 4'(i)}) begin
        n_fail++; $display("FAIL ackdly_word[%0d]: got %0d writes, word mismatch against %h/%h", i, obs_addr.size(), W'(base + W'(i)), dev_words[i]);
      end
    end
    n_checks++; if (done_cycles != 1) begin n_fail++; $display("FAIL ackdly_done_pulse: got %0d expected 1", done_cycles); end
  endtask
  task automatic test_bg_gap();
    logic [W-1:0] base = 16'h0100;
    run_burst(base, 0, 100, 6, -1);
    n_checks++; if (timeout != 0) begin n_fail++; $display("FAIL gap_timeout: burst never completed"); end
    n_checks++; if (bg_viol != 0) begin n_fail++; $display("FAIL gap_bg_gating: got %0d violations expected 0", bg_viol); end
    n_checks++; if (obs_addr.size() != N) begin n_fail++; $display("FAIL gap_count: got %0d writes expected %0d", obs_addr.size(), N); end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (i >= obs_addr.size() || {obs_addr[i], obs_data[i], obs_idx[i]} !== {W'(base + W'(i)), dev_words[i], 4'(i)}) begin
        n_fail++; $display("FAIL gap_word[%0d]: got %0d writes, word mismatch against %h/%h", i, obs_addr.size(), W'(base + W'(i)), dev_words[i]);
      end
    end
  endtask
  task automatic test_wrap();
    logic [W-1:0] base = 16'hFFFA;
    run_burst(base, 1, 70, -1, -1);
    n_checks++; if (timeout != 0) begin n_fail++; $display("FAIL wrap_timeout: burst never completed"); end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (i >= obs_addr.size() || {obs_addr[i], obs_data[i]} !== {W'(base + W'(i)), dev_words[i]}) begin
        n_fail++; $display("FAIL wrap_word[%0d]: got %0d writes, word mismatch against %h/%h", i, obs_addr.size(), W'(base + W'(i)), dev_words[i]);
      end
    end
  endtask
  task automatic test_reset_mid();
    logic [W-1:0] base = W'($urandom);
    run_burst(16'h0400, 0, 100, -1, 4);
    n_checks++; if (timeout != 0) begin n_fail++; $display("FAIL rstmid_timeout: never reached word 4"); end
    n_checks++; if ({rst_br, rst_mw, rst_ready, rst_done, rst_state} !== 8'b0010_0000) begin
      n_fail++; $display("FAIL rstmid_outputs: got BR=%b mw=%b ready=%b done=%b state=%0d expected BR=0 mw=0 ready=1 done=0 state=0", rst_br, rst_mw, rst_ready, rst_done, rst_state);
    end
    run_burst(base, 0, 100, -1, -1);
    n_checks++; if (timeout != 0 || done_cycles != 1) begin n_fail++; $display("FAIL rstmid_rerun_done: got %0d done cycles timeout=%0d expected 1 and 0", done_cycles, timeout); end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (i >= obs_addr.size() || {obs_addr[i], obs_data[i], obs_idx[i]} !== {W'(base + W'(i)), dev_words[i], 4'(i)}) begin
        n_fail++; $display("FAIL rstmid_word[%0d]: got %0d writes, word mismatch against %h/%h", i, obs_addr.size(), W'(base + W'(i)), dev_words[i]);
      end
    end
  endtask
  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      logic [W-1:0] base = W'($urandom);
      run_burst(base, $urandom_range(0, 2), $urandom_range(30, 100), $urandom_range(0, 1) ? $urandom_range(1, N - 1) : -1, -1);
      n_checks++; if (timeout != 0 || done_cycles != 1) begin n_fail++; $display("FAIL rand%0d_done: got %0d done cycles timeout=%0d expected 1 and 0", k, done_cycles, timeout); end
      n_checks++; if (unstable != 0 || bg_viol != 0) begin n_fail++; $display("FAIL rand%0d_protocol: got unstable=%0d bg_viol=%0d expected 0 and 0", k, unstable, bg_viol); end
      n_checks++; if (obs_addr.size() != N) begin n_fail++; $display("FAIL rand%0d_count: got %0d writes expected %0d", k, obs_addr.size(), N); end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (i >= obs_addr.size() || {obs_addr[i], obs_data[i], obs_idx[i]} !== {W'(base + W'(i)), dev_words[i], 4'(i)}) begin
          n_fail++; $display("FAIL rand%0d_word[%0d]: word mismatch against %h/%h", k, i, W'(base + W'(i)), dev_words[i]);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_ack_delay();
    test_bg_gap();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_controller.md
# dma_controller

Bus-mastering DMA engine that moves a fixed burst of words from an external device into data memory on behalf of the CPU. It is the initiator side of the BR/BG bus-arbitration handshake: it raises BR, waits for the CPU to stall and grant the bus, streams the burst while publishing its progress on `dma_state`, then releases the bus and interrupts the CPU. It sits beside the CPU core, between the device port and the data-memory port.

## Interface
Parameters:
- `WORD_SIZE`, 16: data and address width.
- `BURST_WORDS`, 12: words per command; `dma_state` counts 0..BURST_WORDS-1.
- `BLOCK_WORDS`, 4: words per cycle-steal block (used only with `DMA_CYCLE_STEAL_EN`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `cmd_valid`  in  1  CPU issues a DMA command.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_addr`  in  WORD_SIZE  memory base address, captured on accept.
- `BR`  out  1  bus request to CPU.
- `BG`  in  1  bus grant from CPU.
- `dev_valid`  in  1  device word available.
- `dev_data`  in  WORD_SIZE  device word.
- `dev_ready`  out  1  controller accepts a device word.
- `mem_write`  out  1  memory write request.
- `mem_addr`  out  WORD_SIZE  write address.
- `mem_data`  out  WORD_SIZE  write data.
- `mem_ack`  in  1  memory accepted the write this cycle.
- `dma_state`  out  4  index of current word.
- `dma_done`  out  1  one-cycle completion interrupt.

## Operation
- States: IDLE, REQ, XFER, RELEASE, DONE.
- IDLE: `cmd_ready`=1; on `cmd_valid`, capture `cmd_addr`, clear index, go REQ. Commands in any other state are ignored (`cmd_ready`=0).
- REQ: `BR`=1; on `BG`=1 go XFER.
- XFER: `BR`=1. Single-entry word buffer. `dev_ready` = buffer empty && `BG`. Capture on `dev_valid && dev_ready`. While buffer full and `BG`=1: `mem_write`=1, `mem_addr` = base + index (mod 2^WORD_SIZE, wraps), `mem_data` = buffer. On `mem_ack`: empty buffer; if index == BURST_WORDS-1 go RELEASE, else index+1.
- `BG` falling during XFER: `mem_write` and `dev_ready` forced 0, buffer and index held, resume when `BG` returns; no word lost or duplicated.
- RELEASE: `BR`=0; wait `BG`=0, then DONE.
- DONE: `dma_done`=1 for exactly one cycle, then IDLE, index cleared to 0.
- `dma_state` = index; holds BURST_WORDS-1 (11) from the last word's write through RELEASE and DONE. The CPU's arbitration logic keys its release on value 11.
- `mem_ack` without `mem_write` is ignored.

## Timing
- All outputs registered-state-derived; reset values: `cmd_ready`=1, `BR`=0, `dev_ready`=0, `mem_write`=0, `mem_addr`=0, `mem_data`=0, `dma_state`=0, `dma_done`=0.
- Command accepted at edge T -> `BR`=1 from T+1.
- `BG` sampled high at edge -> XFER the following cycle.
- Per word minimum 2 cycles: capture edge, then `mem_write` cycle acked by zero-wait `mem_ack`. Full burst minimum 24 XFER cycles.
- Last `mem_ack` at edge E -> `BR`=0 from E+1; `dma_done` pulses the cycle after `BG` is sampled low.
- Reset asserted mid-burst: immediate return to IDLE, all outputs to reset values, transfer abandoned.

## Configuration
- `DMA_CYCLE_STEAL_EN` defined: after each acked word whose index is a multiple-of-BLOCK_WORDS boundary (index 3, 7), controller goes RELEASE-like (`BR`=0, wait `BG`=0) then REQ again; index and base preserved; `dma_done` only after final block. Lets the CPU run between blocks.
- Undefined: single continuous burst, `BR` held from REQ to RELEASE.

## Structure
- Shared package/header: state encoding, `BURST_WORDS`, `BLOCK_WORDS`, `DMA_LAST_INDEX` (= 11) used by both this block and the CPU arbitration logic.
- One sub-module: `dma_word_buffer` (single-entry valid/data register with load/clear/hold).

## Test plan
- Basic burst, base 0x0100, device always valid, zero-wait ack -> 12 writes to 0x0100..0x010B with device data in order, `dma_state` 0..11, one `dma_done` pulse, `BR` low after last ack.
- `mem_ack` delayed 3 cycles per word -> `mem_write`/`mem_addr`/`mem_data` stable until ack, no index advance early.
- `BG` dropped for 5 cycles at word 6 -> no writes during gap, resume at 0x0106, no duplicate/missing words.
- Base 0xFFFA -> addresses wrap 0xFFFA..0xFFFF, 0x0000..0x0005.
- Reset asserted at word 4 -> next cycle `BR`=0, `mem_write`=0, `dma_state`=0, `cmd_ready`=1; new command runs cleanly.
- With `DMA_CYCLE_STEAL_EN`: `BR` falls after words 3 and 7, re-raises after `BG` low, 3 grants total, single `dma_done`.
